uart_tx_buffered: RTL

Parametrised buffered RS-232 transmitter. It is the successor to the single-byte transmitter: a write FIFO decouples the producer from the line, and frame format (parity, stop bits) and baud divisor are selectable at run time. It sits between the host-side byte producer and the `serial_data_out` pad, alongside the existing receiver.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx_buffered.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous write FIFO with async active-low reset and an always-valid head word.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame FSM with run-time divisor and stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          baud_divisor,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic [DATA_WIDTH-1:0]         transmit_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          serial_data_out,
    output logic                          transmitting_flag,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int                    BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);

    tx_state_t              r_state, r_state_next;
    logic [DIV_WIDTH-1:0]   r_timer, r_timer_next;
    logic [DIV_WIDTH-1:0]   r_div, r_div_next;
    logic [BIT_W-1:0]       r_bit_idx, r_bit_idx_next;
    logic [DATA_WIDTH-1:0]  r_shift, r_shift_next;
    logic                   r_two_stop, r_two_stop_next;
    logic                   r_stop_idx, r_stop_idx_next;
    logic                   r_tx, r_tx_next;

    logic                   w_full, w_empty, w_pop, w_timer_zero;
    logic [DATA_WIDTH-1:0]  w_head;
    logic [DIV_WIDTH-1:0]   w_div_eff;

`ifdef UART_TX_PARITY_EN
    logic                   r_par_en, r_par_en_next;
    logic                   r_par_bit, r_par_bit_next;
`else
    logic                   w_unused_parity;
    assign w_unused_parity = ^parity_mode;
`endif

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (wr_valid),
        .wr_data (transmit_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    assign wr_ready          = !w_full;
    assign serial_data_out   = r_tx;
    assign transmitting_flag = (r_state != IDLE);
    assign w_timer_zero      = (r_timer == '0);
    assign w_div_eff         = (baud_divisor > DIV_ONE) ? baud_divisor : DIV_ONE;
    assign frame_done        = (r_state == STOP) && w_timer_zero && (!r_two_stop || r_stop_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_div      <= DIV_ONE;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_two_stop <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_state    <= r_state_next;
            r_timer    <= r_timer_next;
            r_div      <= r_div_next;
            r_bit_idx  <= r_bit_idx_next;
            r_shift    <= r_shift_next;
            r_two_stop <= r_two_stop_next;
            r_stop_idx <= r_stop_idx_next;
            r_tx       <= r_tx_next;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= r_par_en_next;
            r_par_bit  <= r_par_bit_next;
`endif
        end
    end

    always_comb begin
        r_state_next    = r_state;
        r_div_next      = r_div;
        r_bit_idx_next  = r_bit_idx;
        r_shift_next    = r_shift;
        r_two_stop_next = r_two_stop;
        r_stop_idx_next = r_stop_idx;
        r_tx_next       = r_tx;
        w_pop           = 1'b0;
        // Any bit boundary reloads the timer; otherwise it counts down.
        r_timer_next    = w_timer_zero ? (r_div - DIV_ONE) : (r_timer - DIV_ONE);
`ifdef UART_TX_PARITY_EN
        r_par_en_next   = r_par_en;
        r_par_bit_next  = r_par_bit;
`endif

        case (r_state)
            IDLE: begin
                r_tx_next = LINE_IDLE;
                if (!w_empty) w_pop = 1'b1;
            end
            START: begin
                if (w_timer_zero) begin
                    r_state_next   = DATA;
                    r_bit_idx_next = '0;
                    r_tx_next      = r_shift[0];
                end
            end
            DATA: begin
                if (w_timer_zero) begin
                    if (r_bit_idx == LAST_BIT) begin
                        r_state_next    = STOP;
                        r_stop_idx_next = 1'b0;
                        r_tx_next       = LINE_IDLE;
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            r_state_next = PARITY;
                            r_tx_next    = r_par_bit;
                        end
`endif
                    end else begin
                        r_bit_idx_next = r_bit_idx + 1'b1;
                        r_shift_next   = r_shift >> 1;
                        r_tx_next      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_timer_zero) begin
                    r_state_next    = STOP;
                    r_stop_idx_next = 1'b0;
                    r_tx_next       = LINE_IDLE;
                end
            end
`endif
            STOP: begin
                if (w_timer_zero) begin
                    if (frame_done) begin
                        if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            r_state_next = IDLE;
                            r_tx_next    = LINE_IDLE;
                        end
                    end else begin
                        r_stop_idx_next = 1'b1;
                    end
                end
            end
            default: begin
                r_state_next = IDLE;
                r_tx_next    = LINE_IDLE;
            end
        endcase

        // Frame settings are captured only here, so mid-frame input changes wait for the next pop.
        if (w_pop) begin
            r_state_next    = START;
            r_tx_next       = 1'b0;
            r_timer_next    = w_div_eff - DIV_ONE;
            r_div_next      = w_div_eff;
            r_shift_next    = w_head;
            r_two_stop_next = two_stop;
            r_stop_idx_next = 1'b0;
            r_bit_idx_next  = '0;
`ifdef UART_TX_PARITY_EN
            r_par_en_next   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            r_par_bit_next  = (parity_mode == PAR_ODD) ? ~^w_head : ^w_head;
`endif
        end
    end

endmodule
